// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader.
// Contents:
//   REG_ADDR_W / REG_DATA_W / REG_COUNT : geometry of the 32x64-bit two-read-port register file
//   dump_state_t                        : sweeper FSM state encoding
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int REG_COUNT  = 32;

    // S_CSUM is only reachable when the checksum word is built in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND_A,
        S_SEND_B,
        S_CSUM,
        S_DONE
    } dump_state_t;

endpackage

// File: rtl/regdump_out_stage.sv
// One-entry output holding register for the dump stream.
// Once a word is loaded it stays valid, with data/addr/last frozen, until the
// downstream handshake takes it. A load in the same cycle as a transfer
// replaces the outgoing word without a bubble.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   i_load            : capture i_data/i_addr/i_last and present them as valid
//   i_data/i_addr/i_last : word to present
//   i_ready           : downstream ready
//   o_valid/o_data/o_addr/o_last : presented word
//   o_fire            : transfer happening this cycle (o_valid & i_ready)
module regdump_out_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_fire
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_last;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order between blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_addr  <= i_addr;
            r_last  <= i_last;
        end else if (o_fire) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_fire  = r_valid & i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_last  = r_last;

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side sweeper for the two-read-port register file.
// On start, walks register pairs (port A = even address, port B = odd address),
// snapshots each pair in one FETCH cycle, then streams A and B out over a
// valid/ready interface tagged with their addresses.
// Optional feature (macro REGDUMP_CHECKSUM_EN): an XOR of all transferred
// words is appended as an extra word (addr NUM_REGS-1, out_last=1).
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   start                 : one-cycle dump request, honoured only in IDLE
//   busy                  : dump in progress
//   rdAddrA/rdAddrB       : register file read addresses (registered)
//   rdDataA/rdDataB       : register file read data (combinational from address)
//   out_valid/out_ready   : output handshake
//   out_data/out_addr     : register value and its address
//   out_last              : final word of the dump
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rdAddrA,
    output logic [ADDR_W-1:0] rdAddrB,
    input  logic [DATA_W-1:0] rdDataA,
    input  logic [DATA_W-1:0] rdDataB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [ADDR_W-2:0] LAST_K = (ADDR_W-1)'(NUM_REGS/2 - 1);

    dump_state_t       r_state;
    logic [ADDR_W-2:0] r_k;          // pair index
    logic [DATA_W-1:0] r_buf_b;      // port-B half of the pair snapshot
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
`endif

    logic              w_fire;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_load_last;
    logic              w_last_pair;
    logic [ADDR_W-2:0] w_k_next;

    assign w_last_pair = (r_k == LAST_K);
    assign w_k_next    = r_k + (ADDR_W-1)'(1);

    // Selects what the output stage captures. The port-A word goes straight
    // from the read port into the stage at the FETCH edge, so the stage
    // itself holds the A half of the snapshot.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = rdDataA;
        w_load_addr = {r_k, 1'b0};
        w_load_last = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_load = 1'b1;
            end
            S_SEND_A: begin
                if (w_fire) begin
                    w_load      = 1'b1;
                    w_load_data = r_buf_b;
                    w_load_addr = {r_k, 1'b1};
`ifdef REGDUMP_CHECKSUM_EN
                    w_load_last = 1'b0;
`else
                    w_load_last = w_last_pair;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_SEND_B: begin
                // The word leaving now has not reached r_acc yet; fold it in.
                if (w_fire && w_last_pair) begin
                    w_load      = 1'b1;
                    w_load_data = r_acc ^ out_data;
                    w_load_addr = ADDR_W'(NUM_REGS - 1);
                    w_load_last = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_buf_b <= '0;
            busy    <= 1'b0;
            rdAddrA <= '0;
            rdAddrB <= ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
            r_acc   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        rdAddrA <= '0;
                        rdAddrB <= ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
                        r_acc   <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    r_buf_b <= rdDataB;
                    r_state <= S_SEND_A;
                end
                S_SEND_A: begin
                    if (w_fire) begin
`ifdef REGDUMP_CHECKSUM_EN
                        r_acc   <= r_acc ^ out_data;
`endif
                        r_state <= S_SEND_B;
                    end
                end
                S_SEND_B: begin
                    if (w_fire) begin
`ifdef REGDUMP_CHECKSUM_EN
                        r_acc <= r_acc ^ out_data;
`endif
                        if (w_last_pair) begin
`ifdef REGDUMP_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_DONE;
                            busy    <= 1'b0;
`endif
                        end else begin
                            // Addresses advance here so they are settled for
                            // the whole FETCH cycle of the next pair.
                            r_k     <= w_k_next;
                            rdAddrA <= {w_k_next, 1'b0};
                            rdAddrB <= {w_k_next, 1'b1};
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_fire) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    regdump_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_addr  (w_load_addr),
        .i_last  (w_load_last),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_addr  (out_addr),
        .o_last  (out_last),
        .o_fire  (w_fire)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader. Stimulus pushes the expected
// word stream when a dump is started; an independent monitor pops and
// compares on every handshake and checks stability on stalled cycles.
module tb_regfile_dump_reader;

    localparam int NREG = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int NUM_WORDS = NREG + 1;
`else
    localparam int NUM_WORDS = NREG;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [4:0]  rdAddrA, rdAddrB;
    logic [63:0] rdDataA, rdDataB;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;

    logic [63:0] regs [NREG];
    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_words = 0;
    int   ready_mode = 0;   // 0: always 1, 1: pattern 1,0,0,1, 2: stall on addr 15
    int   exp_kind = 0;     // 0: 1111_0000_0000_0000+i, 1: i, 2: 1<<i
    bit   dead_mode = 1'b0; // reg 4 holds DEAD_BEEF_0000_0004

    regfile_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .rdDataA   (rdDataA),
        .rdDataB   (rdDataB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_val(input int i);
        logic [63:0] v;
        case (exp_kind)
            1:       v = 64'(i);
            2:       v = 64'h1 << i;
            default: v = 64'h1111_0000_0000_0000 + 64'(i);
        endcase
        if (dead_mode && i == 4) v = 64'hDEAD_BEEF_0000_0004;
        return v;
    endfunction

    task automatic preload();
        for (int i = 0; i < NREG; i++) regs[i] = exp_val(i);
    endtask

    // Expected stream for one complete dump.
    task automatic push_dump(input logic [63:0] csum);
        exp_t e;
        for (int i = 0; i < NREG; i++) begin
            e.addr = 5'(i);
            e.data = exp_val(i);
`ifdef REGDUMP_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (i == NREG - 1);
`endif
            sb.push_back(e);
        end
`ifdef REGDUMP_CHECKSUM_EN
        e.addr = 5'(NREG - 1);
        e.data = csum;
        e.last = 1'b1;
        sb.push_back(e);
`else
        if (csum != 64'h0) e.data = csum; // checksum word absent in this build
`endif
    endtask

    task automatic start_dump(input logic [63:0] csum);
        push_dump(csum);
        n_words = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("valid_in_fetch", out_valid, 0);
        check("fetch_addr_a", rdAddrA, 0);
        check("fetch_addr_b", rdAddrB, 1);
        @(posedge clk);
        #1;
        check("first_valid", out_valid, 1);
        check("first_addr", out_addr, 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
    endtask

    task automatic check_complete(input string name);
        check({name, "_words"}, 64'(n_words), 64'(NUM_WORDS));
        check({name, "_sb_empty"}, 64'(sb.size()), 0);
    endtask

    // out_ready is driven just after each rising edge.
    initial begin : ready_drv
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    out_ready = pat[ph];
                    ph = (ph + 1) % 4;
                end
                2:       out_ready = !(out_valid && out_addr == 5'd15);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares on handshake, checks hold on stalled cycles.
    initial begin : monitor
        exp_t        e;
        bit          stalled;
        logic [63:0] h_data;
        logic [4:0]  h_addr;
        logic        h_last;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, h_data);
                    check("stall_addr", out_addr, h_addr);
                    check("stall_last", out_last, h_last);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL extra_word: got word at addr %0d, expected none", out_addr);
                    end else begin
                        e = sb.pop_front();
                        check("word_addr", out_addr, e.addr);
                        check("word_data", out_data, e.data);
                        check("word_last", out_last, e.last);
                        n_words++;
                    end
                end
                stalled = out_valid && !out_ready;
                h_data  = out_data;
                h_addr  = out_addr;
                h_last  = out_last;
            end
        end
    end

    initial begin : stim
        int k;
        exp_kind = 0;
        preload();
        #23;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", out_addr, 0);
        check("rst_rdaddr_a", rdAddrA, 0);
        check("rst_rdaddr_b", rdAddrB, 1);
        @(negedge clk);
        reset = 1'b1;

        // 1: ready held high, full dump (XOR of 1111..+i over 32 words is 0)
        ready_mode = 0;
        start_dump(64'h0);
        wait_idle(200);
        check_complete("dump_ready_high");

        // 2: ready pattern 1,0,0,1
        ready_mode = 1;
        start_dump(64'h0);
        wait_idle(400);
        check_complete("dump_ready_toggle");
        ready_mode = 0;

        // 3: start mid-dump ignored; start in DONE ignored
        start_dump(64'h0);
        k = 0;
        while (n_words < 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
        check_complete("restart_ignored");
        start = 1'b1;               // this cycle is DONE
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_start_busy", busy, 0);
        check("done_start_valid", out_valid, 0);

        // 4: reset while addr 15 (SEND_B of pair 7) is stalled
        ready_mode = 2;
        start_dump(64'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(out_valid && out_addr == 5'd15) && k < 200);
        check("reached_addr15", out_addr, 15);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rdaddr_a", rdAddrA, 0);
        check("abort_rdaddr_b", rdAddrB, 1);
        sb.delete();
        ready_mode = 0;
        @(negedge clk);
        reset = 1'b1;
        start_dump(64'h0);
        wait_idle(200);
        check_complete("dump_after_abort");

        // 5: write to reg 4 lands after FETCH of pair 2
        start_dump(64'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (rdAddrA != 5'd4 && k < 200);
        check("fetch_pair2_addr", rdAddrA, 4);
        @(posedge clk);
        #1 regs[4] = 64'hDEAD_BEEF_0000_0004;
        wait_idle(200);
        check_complete("dump_old_value");
        dead_mode = 1'b1;
        start_dump(64'hCFBC_BEEF_0000_0000);
        wait_idle(200);
        check_complete("dump_new_value");
        dead_mode = 1'b0;

`ifdef REGDUMP_CHECKSUM_EN
        // 6: checksum word over known patterns
        exp_kind = 1;
        preload();
        start_dump(64'h0);
        wait_idle(200);
        check_complete("csum_index");
        exp_kind = 2;
        preload();
        start_dump(64'hFFFF_FFFF);
        wait_idle(200);
        check_complete("csum_onehot");
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
